// File: rtl/decode_stage.sv
// decode_stage: single-slot ARM decode stage with condition check, branch resolution and post-branch kill
// Ports:
//   clock, reset_n               rising-edge clock, synchronous active-low reset
//   instr, pc_in                 instruction word and its address from fetch
//   in_valid, in_ready           upstream handshake
//   flags_in                     current flags, [3]=Z [2]=C [1]=N [0]=V
//   out_valid, out_ready         downstream handshake to execute
//   sel_p0, sel_p1, sel_in       Rn, Rm, Rd register selects
//   uop, imm, use_imm            ALU micro-op, rotated immediate, immediate-operand select
//   write_en, set_flags          writeback enable, flag update enable
//   pc_out                       address of the issued instruction
//   branch_taken, branch_target  one-cycle taken pulse and destination
//   undef                        issued slot holds an unsupported encoding
module decode_stage (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic [31:0] pc_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  flags_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  sel_p0,
    output logic [3:0]  sel_p1,
    output logic [3:0]  sel_in,
    output logic [4:0]  uop,
    output logic [31:0] imm,
    output logic        use_imm,
    output logic        write_en,
    output logic        set_flags,
    output logic [31:0] pc_out,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        undef
);
    logic        z, c, n, v;
    logic        cond_pass, kill, accept;
    logic        is_dp, is_b, cmp_op, bad, bubble, live;
    logic [31:0] imm_rot;

    assign {z, c, n, v} = flags_in;
    // Forced high while reset is held so upstream never sees a stale stall
    assign in_ready = !reset_n || !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        cond_pass = 1'b1;
        case (instr[31:28])
            4'h0: cond_pass = z;
            4'h1: cond_pass = !z;
            4'h2: cond_pass = c;
            4'h3: cond_pass = !c;
            4'h4: cond_pass = n;
            4'h5: cond_pass = !n;
            4'h6: cond_pass = v;
            4'h7: cond_pass = !v;
            4'h8: cond_pass = c && !z;
            4'h9: cond_pass = !c || z;
            4'hA: cond_pass = n == v;
            4'hB: cond_pass = n != v;
            4'hC: cond_pass = !z && (n == v);
            4'hD: cond_pass = z || (n != v);
            default: cond_pass = 1'b1;
        endcase
    end

    // Register form is only supported unshifted
    assign is_dp  = instr[27:26] == 2'b00 && (instr[25] || instr[11:4] == 8'h00);
    assign is_b   = instr[27:24] == 4'b1010;
    assign cmp_op = instr[24:23] == 2'b10;
    // Kill and condition failure outrank an unsupported encoding; cond 1111 is never a bubble
    assign bubble = kill || (instr[31:28] != 4'hF && !cond_pass);
    assign bad    = instr[31:28] == 4'hF || !(is_dp || is_b);
    assign live   = !bubble && !bad;
    // Rotate right of the 8-bit field: low word of the doubled value shifted right
    assign imm_rot = 32'({2{24'h0, instr[7:0]}} >> {instr[11:8], 1'b0});

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            kill          <= 1'b0;
            branch_taken  <= 1'b0;
            undef         <= 1'b0;
            write_en      <= 1'b0;
            set_flags     <= 1'b0;
            use_imm       <= 1'b0;
            uop           <= 5'd0;
            sel_p0        <= 4'd0;
            sel_p1        <= 4'd0;
            sel_in        <= 4'd0;
            imm           <= 32'd0;
            pc_out        <= 32'd0;
            branch_target <= 32'd0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            kill          <= live && is_b;
            branch_taken  <= live && is_b;
            undef         <= !bubble && bad;
            write_en      <= live && is_dp && !cmp_op;
            set_flags     <= live && is_dp && (cmp_op || instr[20]);
            use_imm       <= is_dp && instr[25];
            uop           <= is_dp ? {1'b0, instr[24:21]} : 5'd0;
            sel_p0        <= is_dp ? instr[19:16] : 4'd0;
            sel_p1        <= is_dp ? instr[3:0] : 4'd0;
            sel_in        <= is_dp ? instr[15:12] : 4'd0;
            imm           <= is_dp && instr[25] ? imm_rot : 32'd0;
            pc_out        <= pc_in;
            branch_target <= pc_in + 32'd8 + {{6{instr[23]}}, instr[23:0], 2'b00};
        end else begin
            // The taken pulse lasts one cycle even while the slot is stalled
            branch_taken <= 1'b0;
            if (out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checking of decode_stage against a behavioural model
module tb_decode_stage;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [31:0] pc_in = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  flags_in = 4'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  sel_p0, sel_p1, sel_in;
    logic [4:0]  uop;
    logic [31:0] imm, pc_out, branch_target;
    logic        use_imm, write_en, set_flags, branch_taken, undef;

    int tests = 0;
    int fails = 0;

    localparam bit [1:0] K_BUB = 2'd0, K_DP = 2'd1, K_BR = 2'd2, K_UND = 2'd3;

    typedef struct packed {
        bit        valid;
        bit [1:0]  kind;
        bit        we, sf, bt, und, use_imm;
        bit [4:0]  uop;
        bit [3:0]  p0, p1, rd;
        bit [31:0] imm, pc, tgt;
    } exp_t;

    exp_t m;
    bit   m_kill = 0;
    bit   m_zero = 0;
    bit   started = 0;

    decode_stage dut (
        .clock(clock), .reset_n(reset_n), .instr(instr), .pc_in(pc_in),
        .in_valid(in_valid), .in_ready(in_ready), .flags_in(flags_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sel_p0(sel_p0), .sel_p1(sel_p1), .sel_in(sel_in), .uop(uop),
        .imm(imm), .use_imm(use_imm), .write_en(write_en), .set_flags(set_flags),
        .pc_out(pc_out), .branch_taken(branch_taken), .branch_target(branch_target),
        .undef(undef)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc, input logic [3:0] f, input bit kill);
        exp_t e;
        bit z, c, n, v, pass, cmpop;
        logic [31:0] r;
        int off;
        e = '0;
        z = f[3]; c = f[2]; n = f[1]; v = f[0];
        e.valid = 1;
        e.pc = pc;
        case (i[31:28])
            4'd0: pass = z;
            4'd1: pass = !z;
            4'd2: pass = c;
            4'd3: pass = !c;
            4'd4: pass = n;
            4'd5: pass = !n;
            4'd6: pass = v;
            4'd7: pass = !v;
            4'd8: pass = c && !z;
            4'd9: pass = !c || z;
            4'd10: pass = n == v;
            4'd11: pass = n != v;
            4'd12: pass = !z && n == v;
            4'd13: pass = z || n != v;
            default: pass = 1;
        endcase
        if (kill || (i[31:28] != 4'hF && !pass)) begin
            e.kind = K_BUB;
            return e;
        end
        if (i[31:28] == 4'hF) begin
            e.kind = K_UND;
            e.und = 1;
        end else if (i[27:26] == 2'b00 && (i[25] || i[11:4] == 8'h0)) begin
            e.kind = K_DP;
            e.uop = {1'b0, i[24:21]};
            e.p0 = i[19:16];
            e.rd = i[15:12];
            e.p1 = i[3:0];
            e.use_imm = i[25];
            r = {24'h0, i[7:0]};
            for (int k = 0; k < 2 * int'(i[11:8]); k++) r = {r[0], r[31:1]};
            e.imm = r;
            cmpop = i[24:23] == 2'b10;
            e.we = !cmpop;
            e.sf = cmpop || i[20];
        end else if (i[27:24] == 4'b1010) begin
            e.kind = K_BR;
            e.bt = 1;
            off = int'(i[23:0]);
            if (i[23]) off = off - 32'h0100_0000;
            e.tgt = pc + 32'd8 + 32'(off * 4);
        end else begin
            e.kind = K_UND;
            e.und = 1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 2) != 0) w[31:28] = 4'hE;
        case ($urandom_range(0, 5))
            0: w[27:25] = 3'b001;
            1: begin w[27:25] = 3'b000; w[11:4] = 8'h0; end
            2: begin w[27:25] = 3'b000; w[11:4] = 8'($urandom_range(1, 255)); end
            3: w[27:24] = 4'b1010;
            4: w[27:24] = 4'b1011;
            default: w[27:26] = $urandom_range(0, 1) ? 2'b01 : 2'b11;
        endcase
        return w;
    endfunction

    always @(posedge clock) begin
        if (!reset_n) begin
            m = '0;
            m_kill = 0;
            m_zero = 1;
            started = 1;
        end else if (in_valid && (!m.valid || out_ready)) begin
            m = model(instr, pc_in, flags_in, m_kill);
            m_kill = m.bt;
            m_zero = 0;
        end else begin
            m.bt = 0;
            if (out_ready) m.valid = 0;
        end
    end

    always @(negedge clock) if (started) begin
        chk("out_valid", {31'h0, out_valid}, {31'h0, m.valid});
        chk("in_ready", {31'h0, in_ready}, {31'h0, !reset_n || !m.valid || out_ready});
        if (m_zero) begin
            chk("rst_ctrl", {27'h0, write_en, set_flags, use_imm, undef, branch_taken}, 32'h0);
            chk("rst_sel", {15'h0, sel_p0, sel_p1, sel_in, uop}, 32'h0);
            chk("rst_imm", imm, 32'h0);
            chk("rst_pc", pc_out, 32'h0);
            chk("rst_tgt", branch_target, 32'h0);
        end else if (m.valid) begin
            chk("ctrl", {28'h0, write_en, set_flags, undef, branch_taken},
                {28'h0, m.we, m.sf, m.und, m.bt});
            chk("pc_out", pc_out, m.pc);
            if (m.kind == K_DP) begin
                chk("sel", {15'h0, sel_p0, sel_p1, sel_in, uop}, {15'h0, m.p0, m.p1, m.rd, m.uop});
                chk("use_imm", {31'h0, use_imm}, {31'h0, m.use_imm});
                if (m.use_imm) chk("imm", imm, m.imm);
            end
            if (m.bt) chk("target", branch_target, m.tgt);
        end
    end

    task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [3:0] f,
                         input logic iv, input logic ordy);
        instr = i; pc_in = p; flags_in = f; in_valid = iv; out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        exp_t e;
        e = model(32'hE3A01CFF, 32'h0, 4'h0, 0);
        chk("model_rot_imm", e.imm, 32'h0000FF00);
        e = model(32'h0A000002, 32'h100, 4'b1000, 0);
        chk("model_beq_tgt", e.tgt, 32'h110);
        e = model(32'hEAFFFFFE, 32'h0, 4'h0, 0);
        chk("model_neg_tgt", e.tgt, 32'h0);
        // reset
        drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
        tick(); tick();
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        reset_n = 1'b1;
        #1 chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
        // SUB r2,r1,r0
        drive(32'hE0412000, 32'h0, 4'h0, 1'b1, 1'b1);
        tick();
        chk("sub_uop", {27'h0, uop}, 32'h02);
        chk("sub_sels", {20'h0, sel_p0, sel_p1, sel_in}, 32'h102);
        chk("sub_we_imm", {30'h0, write_en, use_imm}, 32'h2);
        // MOV r1,#0xFF00
        drive(32'hE3A01CFF, 32'h4, 4'h0, 1'b1, 1'b1);
        tick();
        chk("mov_imm", imm, 32'h0000FF00);
        chk("mov_uop", {23'h0, use_imm, uop, sel_in}, {23'h0, 1'b1, 5'h0D, 4'h1});
        // BEQ taken, then killed SUB, then normal SUB
        drive(32'h0A000002, 32'h100, 4'b1000, 1'b1, 1'b1);
        tick();
        chk("beq_taken", {31'h0, branch_taken}, 32'h1);
        chk("beq_tgt", branch_target, 32'h110);
        drive(32'hE0412000, 32'h104, 4'h0, 1'b1, 1'b1);
        tick();
        chk("killed", {29'h0, out_valid, write_en, branch_taken}, 32'h4);
        tick();
        chk("after_kill_we", {31'h0, write_en}, 32'h1);
        // BEQ not taken
        drive(32'h0A000002, 32'h100, 4'b0000, 1'b1, 1'b1);
        tick();
        chk("beq_nt", {28'h0, out_valid, write_en, branch_taken, undef}, 32'h8);
        drive(32'hE0412000, 32'h104, 4'h0, 1'b1, 1'b1);
        tick();
        chk("after_nt_we", {31'h0, write_en}, 32'h1);
        // stall
        drive(32'hE2811001, 32'h200, 4'h0, 1'b1, 1'b1);
        tick();
        drive(32'hE0412000, 32'h204, 4'h0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1 chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
            tick();
            chk("stall_hold", {26'h0, out_valid, uop}, {26'h0, 1'b1, 5'h04});
            chk("stall_imm", imm, 32'h1);
        end
        out_ready = 1'b1;
        #1 chk("resume_in_ready", {31'h0, in_ready}, 32'h1);
        tick();
        chk("resume_uop", {27'h0, uop}, 32'h02);
        // reset during stall with pending kill
        drive(32'h0A000002, 32'h300, 4'b1000, 1'b1, 1'b1);
        tick();
        drive(32'hE0412000, 32'h304, 4'h0, 1'b1, 1'b0);
        tick();
        chk("stall_bt_clear", {30'h0, out_valid, branch_taken}, 32'h2);
        reset_n = 1'b0;
        tick();
        chk("mid_rst", {30'h0, out_valid, branch_taken}, 32'h0);
        chk("mid_rst_tgt", branch_target, 32'h0);
        reset_n = 1'b1;
        drive(32'hE0800001, 32'h400, 4'h0, 1'b1, 1'b1);
        tick();
        chk("add_after_rst", {25'h0, out_valid, write_en, uop}, {25'h0, 1'b1, 1'b1, 5'h04});
        // randomized
        for (int k = 0; k < 4000; k++) begin
            reset_n = $urandom_range(0, 199) != 0;
            drive(rand_instr(), $urandom & 32'hFFFF_FFFC, 4'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            tick();
        end
        reset_n = 1'b1;
        drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clock  input  1  rising-edge clock; all state updates on it.
REQ-002 reset_n  input  1  synchronous reset, active-low; sampled on rising clock edge.
REQ-003 instr  input  32  ARM instruction word from fetch.
REQ-004 pc_in  input  32  address of instr.
REQ-005 in_valid / in_ready  input / output  1 each  upstream handshake; transfer when both high on a clock edge.
REQ-006 flags_in  input  4  current flags from regs, order [3]=Z [2]=C [1]=N [0]=V.
REQ-007 out_valid / out_ready  output / input  1 each  downstream handshake to execute.
REQ-008 sel_p0, sel_p1, sel_in  output  4 each  register selects: Rn, Rm, Rd.
REQ-009 uop  output  5  ALU micro-op.
REQ-010 imm  output  32  decoded rotated immediate; use_imm  output  1  RHS = imm instead of p1.
REQ-011 write_en, set_flags  output  1 each  result writeback enable; flag update enable.
REQ-012 pc_out  output  32  pc of the issued instruction.
REQ-013 branch_taken  output  1  one-cycle pulse; branch_target  output  32  destination.
REQ-014 undef  output  1  issued slot holds an unsupported encoding.

Function
REQ-015 in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-016 On accept (in_valid && in_ready) all decoded outputs SHALL register on that edge; latency 1 cycle; out_valid high the next cycle.
REQ-017 With out_valid && !out_ready, all outputs SHALL hold stable.
REQ-018 With out_ready high and no accept, out_valid SHALL clear on the next edge.
REQ-019 Data-processing (bits[27:26]=00): uop = {1'b0, instr[24:21]} (AND=00000, SUB=00010, ADD=00100, MOV=01101, MVN=01111); sel_p0=instr[19:16], sel_in=instr[15:12], sel_p1=instr[3:0], set_flags=instr[20].
REQ-020 Immediate form (bit25=1): use_imm=1, imm = zero-extended instr[7:0] rotated right by 2*instr[11:8]. bit25=0 with instr[11:4]!=0 (shifted register) SHALL decode as undef.
REQ-021 TST/TEQ/CMP/CMN (opcode 10xx): write_en=0, set_flags=1; all other data-processing ops: write_en=1.
REQ-022 Condition instr[31:28] SHALL be evaluated against flags_in at accept: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 -> undef.
REQ-023 Condition fail SHALL issue a bubble: out_valid=1, write_en=0, set_flags=0, branch_taken=0, undef=0.
REQ-024 Branch B (bits[27:25]=101, bit24=0): write_en=0, set_flags=0; target = pc_in + 8 + (sign-extended instr[23:0] << 2), 32-bit wrap-around; bit24=1 (BL) SHALL decode as undef.
REQ-025 Branch with condition pass SHALL assert branch_taken for exactly the first cycle out_valid is high for that slot, regardless of out_ready.
REQ-026 After a taken branch the next accepted instruction SHALL be killed (issued as bubble per REQ-023); kill state clears after that one accept.
REQ-027 Any other encoding: undef=1, write_en=0, set_flags=0.
REQ-028 No flag forwarding: flags_in is used as presented; hazard avoidance is upstream's responsibility.

Reset
REQ-029 reset_n low at an edge SHALL clear out_valid, branch_taken, undef, write_en, set_flags, use_imm, kill state; selects, uop, imm, pc_out, branch_target to 0.
REQ-030 reset_n asserted mid-stall or with pending kill SHALL discard both; first instruction after release SHALL issue normally.
REQ-031 in_ready SHALL be 1 during and immediately after reset.

Verification
REQ-032 instr=0xE0412000 (SUB r2,r1,r0), out_ready=1 -> next cycle uop=00010, sel_p0=1, sel_p1=0, sel_in=2, write_en=1, use_imm=0.
REQ-033 instr=0xE3A01CFF (MOV r1,#0xFF00... rot 12*2) -> imm=0x0000FF00, use_imm=1, uop=01101, sel_in=1.
REQ-034 instr=0x0A000002 (BEQ) at pc_in=0x100, flags_in=4'b1000 -> branch_taken pulse, branch_target=0x110; next accepted instr issues with write_en=0.
REQ-035 Same BEQ with flags_in=4'b0000 -> bubble, branch_taken=0; following instr issues normally.
REQ-036 out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 -> next instruction accepted same edge.
REQ-037 reset_n=0 for one edge during stall with pending kill -> out_valid=0, branch_taken=0, all outputs 0; next ADD issues with write_en=1.
